serial_comparator: RTL and testbench
====================================

// Module: serial_comparator
// PURPOSE
//  Multi-cycle magnitude comparator for wide operands. Compares DIGIT_WIDTH bits per
//  cycle, MSB digit first, and stops at the first differing digit. Supports signed and
//  unsigned modes. Uses valid/ready handshakes on both sides, for datapaths where a
//  full-width single-cycle compare would break timing.
// PARAMETERS
//  DATA_WIDTH   8  operand width in bits; must be a multiple of DIGIT_WIDTH
//  DIGIT_WIDTH  2  bits compared per cycle; >=1; NUM_DIGITS = DATA_WIDTH/DIGIT_WIDTH
//  EARLY_EXIT   1  1: finish at first differing digit; 0: always scan all NUM_DIGITS
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  in_valid     in   1           operand pair valid
//  in_ready     out  1           block can accept operands (high only in IDLE)
//  operand_a    in   DATA_WIDTH  first operand
//  operand_b    in   DATA_WIDTH  second operand
//  signed_mode  in   1           1: two's-complement compare; 0: unsigned
//  out_valid    out  1           result valid
//  out_ready    in   1           consumer accepts result
//  less         out  1           operand_a < operand_b
//  equal        out  1           operand_a == operand_b
//  greater      out  1           operand_a > operand_b
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, out_valid=0, less=equal=greater=0.
//    in_ready=1 once rst_n is high.
//  - FSM states: IDLE, CMP, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  - IDLE: on in_valid && in_ready, register operands and signed_mode, set digit index
//    to NUM_DIGITS-1, go to CMP. In signed mode, invert bit DATA_WIDTH-1 of both
//    registered operands. Unsigned compare of the biased values is then correct.
//  - CMP, one digit per cycle:
//    - digit_a != digit_b: latch the first difference into lt/gt.
//    - EARLY_EXIT=1: on a difference go to DONE. Else, if index==0, go to DONE with
//      equal; else decrement index.
//    - EARLY_EXIT=0: keep the first difference and ignore later digits. Go to DONE
//      after index 0.
//  - Latency: out_valid rises k cycles after the accepting edge. k = 1-based position
//    (from MSB) of the deciding digit. k = NUM_DIGITS when operands are equal or
//    EARLY_EXIT=0.
//  - DONE: less/equal/greater are exactly one-hot and held stable until
//    out_valid && out_ready. On that edge: go to IDLE, clear all three flags to 0.
//  - less/equal/greater are 0 whenever out_valid=0.
//  - Inputs outside IDLE are ignored: no second accept, and operand changes during CMP
//    have no effect. No back-to-back overlap, so minimum throughput is one result per
//    NUM_DIGITS+2 cycles.
//  - Reset mid-CMP or mid-DONE: abort immediately. No out_valid is produced for the
//    aborted operation.
//  - Illegal parameters (DATA_WIDTH % DIGIT_WIDTH != 0, or DIGIT_WIDTH < 1): $error
//    at elaboration.
// TESTING (DATA_WIDTH=8, DIGIT_WIDTH=2 unless stated)
//  1. unsigned a=0xA5, b=0x35 -> greater=1, less=equal=0; out_valid 1 cycle after accept
//  2. a=b=0x3C -> equal=1; out_valid 4 cycles after accept; in_ready=0 throughout
//  3. a=0x80, b=0x01: signed_mode=1 -> less=1; signed_mode=0 -> greater=1
//  4. out_ready=0 for 5 cycles in DONE -> flags stable, in_ready=0; a pulse of in_valid
//     is ignored. Then out_ready=1 -> IDLE, flags 0, in_ready=1 next cycle.
//  5. a=0x01, b=0x02, rst_n low on the 2nd CMP cycle -> flags 0, out_valid never
//     rises; the next transaction compares correctly
//  6. EARLY_EXIT=0, a=0xC0, b=0x00 -> greater=1 at 4 cycles. Then 500 random
//     pairs/modes vs the $signed/unsigned model; assert one-hot whenever out_valid.

Source files
------------

// File: rtl/serial_comparator.sv
// serial_comparator: multi-cycle magnitude comparator, DIGIT_WIDTH bits per cycle from the MSB digit down.
module serial_comparator #(
  parameter int DATA_WIDTH  = 8,
  parameter int DIGIT_WIDTH = 2,
  parameter int EARLY_EXIT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  less,
  output logic                  equal,
  output logic                  greater
);
  localparam int DW_SAFE    = (DIGIT_WIDTH < 1) ? 1 : DIGIT_WIDTH;
  localparam int NUM_DIGITS = DATA_WIDTH / DW_SAFE;
  localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (DIGIT_WIDTH < 1 || (DATA_WIDTH % DW_SAFE) != 0) begin : g_param_err
    $error("serial_comparator: DATA_WIDTH must be a positive multiple of DIGIT_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, sh_a, sh_b;
  logic [DW_SAFE-1:0]    da, db;
  logic [IW-1:0]         idx_q;
  logic                  lt_q, gt_q, lt_d, gt_d, first, last;
  logic                  less_q, equal_q, greater_q;
  logic [DATA_WIDTH-1:0] bias;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign bias  = {signed_mode, {(DATA_WIDTH-1){1'b0}}};
  assign sh_a  = a_q >> (idx_q * DW_SAFE);
  assign sh_b  = b_q >> (idx_q * DW_SAFE);
  assign da    = sh_a[DW_SAFE-1:0];
  assign db    = sh_b[DW_SAFE-1:0];
  assign first = !(lt_q || gt_q);
  assign lt_d  = first ? (da < db) : lt_q;
  assign gt_d  = first ? (da > db) : gt_q;
  assign last  = ((EARLY_EXIT != 0) && (da != db)) || (idx_q == '0);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign less      = less_q;
  assign equal     = equal_q;
  assign greater   = greater_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_q <= CMP;
          a_q     <= operand_a ^ bias;
          b_q     <= operand_b ^ bias;
          idx_q   <= IW'(NUM_DIGITS - 1);
          lt_q    <= 1'b0;
          gt_q    <= 1'b0;
        end
        CMP: begin
          lt_q <= lt_d;
          gt_q <= gt_d;
          if (last) begin
            state_q   <= DONE;
            less_q    <= lt_d;
            greater_q <= gt_d;
            equal_q   <= !(lt_d || gt_d);
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: if (out_ready) begin
          state_q   <= IDLE;
          less_q    <= 1'b0;
          equal_q   <= 1'b0;
          greater_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: checks an EARLY_EXIT=1 and an EARLY_EXIT=0 instance against a plain arithmetic model.
module tb_serial_comparator;
  logic       clk = 1'b0, rst_n = 1'b0, iv1 = 1'b0, iv0 = 1'b0, out_rdy = 1'b0, sm = 1'b0;
  logic [7:0] opa = '0, opb = '0;
  logic       rdy1, ov1, l1, e1, g1, rdy0, ov0, l0, e0, g0;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  serial_comparator #(.DATA_WIDTH(8), .DIGIT_WIDTH(2), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .operand_a(opa), .operand_b(opb),
    .signed_mode(sm), .out_valid(ov1), .out_ready(out_rdy), .less(l1), .equal(e1), .greater(g1));

  serial_comparator #(.DATA_WIDTH(8), .DIGIT_WIDTH(2), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0), .operand_a(opa), .operand_b(opb),
    .signed_mode(sm), .out_valid(ov0), .out_ready(out_rdy), .less(l0), .equal(e0), .greater(g0));

  function automatic logic [2:0] flags(input bit ee);
    return ee ? {l1, e1, g1} : {l0, e0, g0};
  endfunction

  function automatic logic [2:0] exp_flags(input logic [7:0] a, b, input bit s);
    bit lt = s ? ($signed(a) < $signed(b)) : (a < b);
    return {lt, a == b, !lt && a != b};
  endfunction

  // Deciding digit position counted from the MSB; all digits when equal or without early exit.
  function automatic int exp_lat(input bit ee, input logic [7:0] a, b);
    if (!ee) return 4;
    for (int i = 1; i <= 4; i++)
      if (((a >> (8 - 2 * i)) & 3) != ((b >> (8 - 2 * i)) & 3)) return i;
    return 4;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((ov1 && !$onehot({l1, e1, g1})) || (!ov1 && {l1, e1, g1} != 3'b000) ||
          (ov0 && !$onehot({l0, e0, g0})) || (!ov0 && {l0, e0, g0} != 3'b000)) begin
        failures++;
        $display("FAIL onehot ov1=%b f1=%b ov0=%b f0=%b", ov1, {l1, e1, g1}, ov0, {l0, e0, g0});
      end
    end
  end

  task automatic start(input bit ee, input logic [7:0] a, b, input bit s);
    @(negedge clk);
    opa = a; opb = b; sm = s;
    if (ee) iv1 = 1'b1; else iv0 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv0 = 1'b0;
  endtask

  task automatic wait_done(input bit ee, output int lat, output bit rdy_hi);
    lat = 0; rdy_hi = 0;
    while (!(ee ? ov1 : ov0) && lat < 20) begin
      if (ee ? rdy1 : rdy0) rdy_hi = 1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    @(negedge clk); out_rdy = 1'b1;
    @(posedge clk); #1; out_rdy = 1'b0;
  endtask

  task automatic run(input string name, input bit ee, input logic [7:0] a, b, input bit s);
    int lat; bit rdy_hi;
    start(ee, a, b, s);
    wait_done(ee, lat, rdy_hi);
    checks++;
    if (flags(ee) !== exp_flags(a, b, s)) begin
      failures++;
      $display("FAIL %s flags a=%h b=%h s=%b ee=%b got=%b exp=%b", name, a, b, s, ee, flags(ee), exp_flags(a, b, s));
    end
    checks++;
    if (lat != exp_lat(ee, a, b)) begin
      failures++;
      $display("FAIL %s latency a=%h b=%h ee=%b got=%0d exp=%0d", name, a, b, ee, lat, exp_lat(ee, a, b));
    end
    checks++;
    if (rdy_hi) begin
      failures++;
      $display("FAIL %s in_ready high during CMP got=1 exp=0", name);
    end
    pop();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ov1, l1, e1, g1, ov0, l0, e0, g0} !== 8'h00) begin
      failures++;
      $display("FAIL reset outputs got=%b exp=00000000", {ov1, l1, e1, g1, ov0, l0, e0, g0});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rdy1, rdy0} !== 2'b11) begin
      failures++;
      $display("FAIL reset in_ready got=%b exp=11", {rdy1, rdy0});
    end
  endtask

  task automatic test_basic();
    run("ugt", 1, 8'hA5, 8'h35, 0);
    run("eq", 1, 8'h3C, 8'h3C, 0);
    run("slt", 1, 8'h80, 8'h01, 1);
    run("ugt80", 1, 8'h80, 8'h01, 0);
  endtask

  task automatic test_hold();
    int lat; bit rdy_hi;
    logic [2:0] f;
    start(1, 8'h12, 8'h34, 0);
    wait_done(1, lat, rdy_hi);
    f = flags(1);
    checks++;
    if (f !== 3'b100) begin
      failures++;
      $display("FAIL hold result got=%b exp=100", f);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin opa = 8'hFF; opb = 8'h00; iv1 = 1'b1; end else iv1 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({flags(1), rdy1, ov1} !== {f, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL hold cycle%0d got=%b exp=%b", i, {flags(1), rdy1, ov1}, {f, 2'b01});
      end
    end
    iv1 = 1'b0;
    pop();
    checks++;
    if ({ov1, flags(1), rdy1} !== 5'b00001) begin
      failures++;
      $display("FAIL hold release got=%b exp=00001", {ov1, flags(1), rdy1});
    end
    @(posedge clk); #1;
    checks++;
    if ({rdy1, ov1} !== 2'b10) begin
      failures++;
      $display("FAIL hold ignored_pulse got=%b exp=10", {rdy1, ov1});
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    start(1, 8'h01, 8'h02, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov1, flags(1), rdy1} !== 5'b00001) begin
      failures++;
      $display("FAIL abort state got=%b exp=00001", {ov1, flags(1), rdy1});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov1) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort out_valid got=1 exp=0");
    end
    run("after_abort", 1, 8'h01, 8'h02, 0);
  endtask

  task automatic test_no_exit();
    run("noexit", 0, 8'hC0, 8'h00, 0);
    run("noexit_slt", 0, 8'hC0, 8'h00, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      logic [7:0] a = 8'($urandom), b = 8'($urandom);
      if ($urandom_range(3) == 0) b = a;
      run("rand", 1'($urandom), a, b, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_no_exit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
